// File: rtl/multi_string_comparator.sv
// Streaming multi-pattern matcher with a byte window, per-channel hit flags, and a data delay line.
// Optional macro STRCMP_CASE_FOLD_EN makes ASCII letters compare case-insensitively.
`timescale 1ns/1ps
module multi_string_comparator #(
  parameter  int BUS_BYTES = 4,
  parameter  int MAX_LEN   = 17,
  parameter  int NUM_STR   = 4,
  parameter  int DELAY     = 5,
  localparam int SEL_W     = (NUM_STR > 1) ? $clog2(NUM_STR) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     data_valid,
  input  logic [8*BUS_BYTES-1:0]   data_in,
  input  logic                     cfg_we,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic [8*MAX_LEN-1:0]     cfg_string,
  input  logic [5:0]               cfg_len,
  output logic [8*BUS_BYTES-1:0]   data_out,
  output logic                     data_out_valid,
  output logic [NUM_STR-1:0]       match_pulse,
  output logic [NUM_STR-1:0]       match_sticky,
  output logic [15:0]              hit_count
);

  localparam int WIN   = MAX_LEN + BUS_BYTES - 1;
  localparam int W_DAT = 8 * WIN;

  // Window byte 0 is the newest stream byte; older bytes sit at higher indices.
  logic [W_DAT-1:0]       r_win_dat, w_nxt_dat;
  logic [WIN-1:0]         r_win_vld, w_nxt_vld, w_base_vld;

  // Patterns are stored end-aligned: r_pat[c][0] is the last character of the string.
  logic [7:0]             r_pat  [NUM_STR][MAX_LEN];
  logic [MAX_LEN-1:0]     r_mask [NUM_STR];
  logic [NUM_STR-1:0]     r_en;
  logic [7:0]             w_cfg_pat [MAX_LEN];
  logic [MAX_LEN-1:0]     w_cfg_mask;
  logic                   w_cfg_en;

  logic [NUM_STR-1:0]     w_hit;
  logic [8*BUS_BYTES-1:0] r_dly_dat [DELAY];
  logic                   r_dly_vld [DELAY];

`ifdef STRCMP_CASE_FOLD_EN
  function automatic logic [7:0] fold(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  function automatic logic byte_eq(input logic [7:0] a, input logic [7:0] b);
    return fold(a) == fold(b);
  endfunction
`else
  function automatic logic byte_eq(input logic [7:0] a, input logic [7:0] b);
    return a == b;
  endfunction
`endif

  // A clear in the same cycle as a beat drops the old frame but keeps the new beat.
  always_comb begin
    w_base_vld = clear ? '0 : r_win_vld;
    w_nxt_dat  = W_DAT'({r_win_dat, data_in});
    w_nxt_vld  = WIN'({w_base_vld, {BUS_BYTES{1'b1}}});
  end

  always_comb begin
    w_cfg_en = (cfg_len != 6'd0) && (int'(cfg_len) <= MAX_LEN);
    for (int p = 0; p < MAX_LEN; p++) begin
      // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
      w_cfg_pat[p]  = 8'h00;
      w_cfg_mask[p] = 1'b0;
      if (w_cfg_en && (p < int'(cfg_len))) begin
        w_cfg_pat[p]  = cfg_string[8*(MAX_LEN - int'(cfg_len) + p) +: 8];
        w_cfg_mask[p] = 1'b1;
      end
    end
  end

  always_comb begin
    logic w_ok;
    w_hit = '0;
    for (int c = 0; c < NUM_STR; c++) begin
      for (int e = 0; e < BUS_BYTES; e++) begin
        // NOTE: blocking assignments here because w_ok is a running AND evaluated within this block.
        w_ok = r_en[c] & data_valid;
        for (int p = 0; p < MAX_LEN; p++) begin
          if (r_mask[c][p] &&
              !(w_nxt_vld[e+p] && byte_eq(w_nxt_dat[8*(e+p) +: 8], r_pat[c][p])))
            w_ok = 1'b0;
        end
        w_hit[c] = w_hit[c] | w_ok;
      end
    end
  end

  // NOTE: window bytes and pattern bytes carry no reset; their valid tags and enables do.
  always_ff @(posedge clk) begin
    if (data_valid) r_win_dat <= w_nxt_dat;
    if (cfg_we && (int'(cfg_sel) < NUM_STR)) begin
      r_pat[cfg_sel]  <= w_cfg_pat;
      r_mask[cfg_sel] <= w_cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_vld    <= '0;
      r_en         <= '0;
      match_pulse  <= '0;
      match_sticky <= '0;
      hit_count    <= '0;
    end else begin
      if (data_valid)  r_win_vld <= w_nxt_vld;
      else if (clear)  r_win_vld <= '0;
      if (cfg_we && (int'(cfg_sel) < NUM_STR)) r_en[cfg_sel] <= w_cfg_en;
      match_pulse  <= w_hit;
      match_sticky <= w_hit | (match_sticky & ~{NUM_STR{clear}});
      if (clear)
        hit_count <= {15'd0, |w_hit};
      else if (|w_hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        r_dly_dat[i] <= '0;
        r_dly_vld[i] <= 1'b0;
      end
    end else begin
      r_dly_dat[0] <= data_in;
      r_dly_vld[0] <= data_valid;
      for (int i = 1; i < DELAY; i++) begin
        r_dly_dat[i] <= r_dly_dat[i-1];
        r_dly_vld[i] <= r_dly_vld[i-1];
      end
    end
  end

  assign data_out       = r_dly_dat[DELAY-1];
  assign data_out_valid = r_dly_vld[DELAY-1];

endmodule
